// File: rtl/mips_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle MIPS control sequencer.
// Latency: n/a (constants, types and a pure decode function).
// Backpressure: n/a.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_MUL   = 6'b011000;

    localparam logic [1:0] ALU_OP_ADDR  = 2'b00;
    localparam logic [1:0] ALU_OP_RTYPE = 2'b10;

    typedef enum logic [3:0] {
        IDLE, FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB,
        MEM_WRITE, R_EXEC, MUL_WAIT, R_WB, HALT
    } state_t;

    typedef struct packed {
        logic       ir_write;
        logic       pc_write;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       iord;
        logic       mem_to_reg;
        logic       wb_sel_mul;
        logic       alu_src_b;
        logic [1:0] alu_op;
        logic       mul_start;
        logic       busy;
    } ctrl_t;

    // Moore control word for a state; is_mul only matters in DECODE and R_WB.
    function automatic ctrl_t ctrl_for(state_t s, logic is_mul);
        ctrl_t c;
        c = '0;
        case (s)
            FETCH:     c.ir_write = 1'b1;
            DECODE:    c.mul_start = is_mul;
            MEM_ADDR: begin
                c.alu_src_b = 1'b1;
                c.alu_op    = ALU_OP_ADDR;
            end
            MEM_READ: begin
                c.mem_read = 1'b1;
                c.iord     = 1'b1;
            end
            MEM_WB: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
                c.pc_write   = 1'b1;
            end
            MEM_WRITE: begin
                c.mem_write = 1'b1;
                c.iord      = 1'b1;
                c.pc_write  = 1'b1;
            end
            R_EXEC:    c.alu_op = ALU_OP_RTYPE;
            R_WB: begin
                c.reg_write  = 1'b1;
                c.wb_sel_mul = is_mul;
                c.pc_write   = 1'b1;
            end
            default: ;
        endcase
        c.busy = (s != IDLE) && (s != HALT);
        return c;
    endfunction

endpackage

// File: rtl/mips_mc_sequencer_if.sv
// Bundle between sequencer (master) and instruction memory / datapath (slave).
// Latency: n/a (wires only).
// Backpressure: none; mul_done is the only stall input, start the only launch input.
interface mips_mc_sequencer_if #(
    parameter int CNT_W = 16
);
    logic             start;
    logic [31:0]      instr;
    logic             mul_done;
    logic [31:0]      pc;
    logic             ir_write;
    logic             pc_write;
    logic             reg_write;
    logic             mem_read;
    logic             mem_write;
    logic             iord;
    logic             mem_to_reg;
    logic             wb_sel_mul;
    logic             alu_src_b;
    logic [1:0]       alu_op;
    logic             mul_start;
    logic [4:0]       dst_reg;
    logic [4:0]       src_a;
    logic [4:0]       src_b;
    logic [CNT_W-1:0] retired;
    logic             busy;
    logic             done;
    logic             err;

    modport master (
        input  start, instr, mul_done,
        output pc, ir_write, pc_write, reg_write, mem_read, mem_write, iord,
               mem_to_reg, wb_sel_mul, alu_src_b, alu_op, mul_start,
               dst_reg, src_a, src_b, retired, busy, done, err
    );

    modport slave (
        output start, instr, mul_done,
        input  pc, ir_write, pc_write, reg_write, mem_read, mem_write, iord,
               mem_to_reg, wb_sel_mul, alu_src_b, alu_op, mul_start,
               dst_reg, src_a, src_b, retired, busy, done, err
    );
endinterface

// File: rtl/mips_ctrl_decode.sv
// Classifies an instruction word into lw/sw/add/mul/illegal and slices register indices.
// Latency: combinational.
// Backpressure: n/a.
module mips_ctrl_decode
    import mips_ctrl_pkg::*;
(
    input  logic [31:0] ir,
    output logic        is_lw,
    output logic        is_sw,
    output logic        is_add,
    output logic        is_mul,
    output logic        illegal,
    output logic [4:0]  dst_reg,
    output logic [4:0]  src_a,
    output logic [4:0]  src_b
);
    logic [5:0] opcode;
    logic [5:0] funct;

    assign opcode = ir[31:26];
    assign funct  = ir[5:0];

    assign is_lw   = (opcode == OP_LW);
    assign is_sw   = (opcode == OP_SW);
    assign is_add  = (opcode == OP_RTYPE) && (funct == FN_ADD);
    assign is_mul  = (opcode == OP_RTYPE) && (funct == FN_MUL);
    assign illegal = !(is_lw || is_sw || is_add || is_mul);

    assign dst_reg = ir[25:21];
    assign src_a   = ir[20:16];
    assign src_b   = ir[15:11];

    // Shift-amount field is a don't-care for add/mul on this core.
    wire unused_shamt = ^ir[10:6];
endmodule

// File: rtl/mips_mc_sequencer.sv
// Multi-cycle control FSM: fetch/decode lw, sw, add, mul; owns PC and retired count.
// Latency: lw 5, sw/add 4, mul 4+N cycles FETCH-to-FETCH; all outputs registered.
// Backpressure: stalls in MUL_WAIT until mul_done; start honoured only in IDLE/HALT.
module mips_mc_sequencer
    import mips_ctrl_pkg::*;
#(
    parameter logic [31:0] PROG_END = 32'd360,
    parameter int          CNT_W    = 16
)(
    input  logic              clk,
    input  logic              rst_n,
    mips_mc_sequencer_if.master bus
);
    state_t           state_q, nxt_state;
    logic [31:0]      ir_q, nxt_ir;
    logic [31:0]      pc_q, nxt_pc, pc_inc;
    logic [CNT_W-1:0] ret_q, nxt_ret;
    logic             done_q, nxt_done;
    logic             err_q, nxt_err;
    ctrl_t            ctrl_q;
    logic [4:0]       dst_q, srca_q, srcb_q;

    logic             is_lw, is_sw, is_add, is_mul, illegal;
    logic [4:0]       dec_dst, dec_srca, dec_srcb;

    // Decode the IR as it will be next cycle so control and register
    // indices can be registered; outside FETCH this is just ir_q.
    assign nxt_ir = (state_q == FETCH) ? bus.instr : ir_q;
    assign pc_inc = pc_q + 32'd4;

    mips_ctrl_decode u_decode (
        .ir      (nxt_ir),
        .is_lw   (is_lw),
        .is_sw   (is_sw),
        .is_add  (is_add),
        .is_mul  (is_mul),
        .illegal (illegal),
        .dst_reg (dec_dst),
        .src_a   (dec_srca),
        .src_b   (dec_srcb)
    );

    always_comb begin
        nxt_state = state_q;
        nxt_pc    = pc_q;
        nxt_ret   = ret_q;
        nxt_done  = done_q;
        nxt_err   = err_q;
        case (state_q)
            IDLE, HALT: begin
                if (bus.start) begin
                    nxt_state = FETCH;
                    nxt_pc    = '0;
                    nxt_ret   = '0;
                    nxt_done  = 1'b0;
                    nxt_err   = 1'b0;
                end
            end
            FETCH:    nxt_state = DECODE;
            DECODE: begin
                if (illegal) begin
                    nxt_state = HALT;
                    nxt_err   = 1'b1;
                end else if (is_lw || is_sw) begin
                    nxt_state = MEM_ADDR;
                end else if (is_add) begin
                    nxt_state = R_EXEC;
                end else begin
                    nxt_state = MUL_WAIT;
                end
            end
            MEM_ADDR: nxt_state = is_lw ? MEM_READ : MEM_WRITE;
            MEM_READ: nxt_state = MEM_WB;
            R_EXEC:   nxt_state = R_WB;
            MUL_WAIT: if (bus.mul_done) nxt_state = R_WB;
            // Completion: PC update and end-of-program check share the cycle.
            MEM_WB, MEM_WRITE, R_WB: begin
                nxt_pc  = pc_inc;
                nxt_ret = ret_q + CNT_W'(1);
                if (pc_inc >= PROG_END) begin
                    nxt_state = HALT;
                    nxt_done  = 1'b1;
                end else begin
                    nxt_state = FETCH;
                end
            end
            default:  nxt_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ir_q    <= '0;
            pc_q    <= '0;
            ret_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            ctrl_q  <= '0;
            dst_q   <= '0;
            srca_q  <= '0;
            srcb_q  <= '0;
        end else begin
            state_q <= nxt_state;
            ir_q    <= nxt_ir;
            pc_q    <= nxt_pc;
            ret_q   <= nxt_ret;
            done_q  <= nxt_done;
            err_q   <= nxt_err;
            ctrl_q  <= ctrl_for(nxt_state, is_mul);
            dst_q   <= dec_dst;
            srca_q  <= dec_srca;
            srcb_q  <= dec_srcb;
        end
    end

    assign bus.pc         = pc_q;
    assign bus.ir_write   = ctrl_q.ir_write;
    assign bus.pc_write   = ctrl_q.pc_write;
    assign bus.reg_write  = ctrl_q.reg_write;
    assign bus.mem_read   = ctrl_q.mem_read;
    assign bus.mem_write  = ctrl_q.mem_write;
    assign bus.iord       = ctrl_q.iord;
    assign bus.mem_to_reg = ctrl_q.mem_to_reg;
    assign bus.wb_sel_mul = ctrl_q.wb_sel_mul;
    assign bus.alu_src_b  = ctrl_q.alu_src_b;
    assign bus.alu_op     = ctrl_q.alu_op;
    assign bus.mul_start  = ctrl_q.mul_start;
    assign bus.busy       = ctrl_q.busy;
    assign bus.dst_reg    = dst_q;
    assign bus.src_a      = srca_q;
    assign bus.src_b      = srcb_q;
    assign bus.retired    = ret_q;
    assign bus.done       = done_q;
    assign bus.err        = err_q;
endmodule

// File: tb/tb_mips_mc_sequencer.sv
// Randomized bench: an instruction-level model expands each program word into the
// per-cycle control/status it must produce, and every cycle is compared.
// Covers reset, full 90-instruction run, illegal-opcode halt, restart and async reset.
module tb_mips_mc_sequencer;
    localparam int CNT_W   = 16;
    localparam int N_INSTR = 90;

    localparam logic [11:0] IRW  = 12'h800;
    localparam logic [11:0] PCW  = 12'h400;
    localparam logic [11:0] RW   = 12'h200;
    localparam logic [11:0] MR   = 12'h100;
    localparam logic [11:0] MW   = 12'h080;
    localparam logic [11:0] IORD = 12'h040;
    localparam logic [11:0] M2R  = 12'h020;
    localparam logic [11:0] WBM  = 12'h010;
    localparam logic [11:0] ASB  = 12'h008;
    localparam logic [11:0] OPR  = 12'h004;
    localparam logic [11:0] MS   = 12'h001;

    typedef enum int {C_LW, C_SW, C_ADD, C_MUL, C_ILL} cls_t;

    // One expected cycle; md: 0 drive mul_done low, 1 drive high, 2 random.
    typedef struct {
        logic [11:0] ctrl;
        logic [2:0]  stat;
        logic [31:0] pc;
        logic [15:0] ret;
        logic        chk_idx;
        logic [14:0] idx;
        int          md;
    } rec_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mips_mc_sequencer_if #(.CNT_W(CNT_W)) bus();

    mips_mc_sequencer #(.PROG_END(32'd360), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [31:0] imem [0:127];
    cls_t        cls  [0:127];
    int          nmul [0:127];
    rec_t        q[$];

    always_comb bus.instr = (bus.pc < 32'd360) ? imem[bus.pc[8:2]] : 32'hFFFF_FFFF;

    int n_chk  = 0;
    int n_fail = 0;
    int rec_no = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s rec=%0d got=%0h want=%0h", tag, rec_no, obs, exp);
        end
    endtask

    function automatic logic [11:0] obs_ctrl();
        return {bus.ir_write, bus.pc_write, bus.reg_write, bus.mem_read, bus.mem_write,
                bus.iord, bus.mem_to_reg, bus.wb_sel_mul, bus.alu_src_b, bus.alu_op,
                bus.mul_start};
    endfunction

    function automatic logic [31:0] mk_word(cls_t c);
        logic [31:0] w;
        case (c)
            C_LW:    w = {6'b100011, 5'($urandom), 5'($urandom), 16'($urandom)};
            C_SW:    w = {6'b101011, 5'($urandom), 5'($urandom), 16'($urandom)};
            C_ADD:   w = {6'b000000, 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 6'b100000};
            C_MUL:   w = {6'b000000, 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 6'b011000};
            default: w = {6'b000100, 26'($urandom)};
        endcase
        return w;
    endfunction

    task automatic push(input logic [11:0] c, input logic [2:0] st, input int p, input int r,
                        input logic ci, input logic [14:0] ix, input int md);
        rec_t e;
        e.ctrl = c; e.stat = st; e.pc = 32'(p); e.ret = 16'(r);
        e.chk_idx = ci; e.idx = ix; e.md = md;
        q.push_back(e);
    endtask

    // Expected cycles of instruction i; stat bits are {busy, done, err}.
    task automatic model_instr(input int i);
        logic [31:0] w;
        logic [14:0] ix;
        int p;
        w  = imem[i];
        ix = {w[25:21], w[20:16], w[15:11]};
        p  = 4 * i;
        push(IRW, 3'b100, p, i, 1'b0, 15'd0, 2);
        push((cls[i] == C_MUL) ? MS : 12'h000, 3'b100, p, i, 1'b1, ix, 2);
        case (cls[i])
            C_LW: begin
                push(ASB,          3'b100, p, i, 1'b1, ix, 2);
                push(MR | IORD,    3'b100, p, i, 1'b1, ix, 2);
                push(RW | M2R | PCW, 3'b100, p, i, 1'b1, ix, 2);
            end
            C_SW: begin
                push(ASB,            3'b100, p, i, 1'b1, ix, 2);
                push(MW | IORD | PCW, 3'b100, p, i, 1'b1, ix, 2);
            end
            C_ADD: begin
                push(OPR,      3'b100, p, i, 1'b1, ix, 2);
                push(RW | PCW, 3'b100, p, i, 1'b1, ix, 2);
            end
            C_MUL: begin
                for (int k = 0; k <= nmul[i]; k++)
                    push(12'h000, 3'b100, p, i, 1'b1, ix, (k == nmul[i]) ? 1 : 0);
                push(RW | WBM | PCW, 3'b100, p, i, 1'b1, ix, 2);
            end
            default: begin
                push(12'h000, 3'b001, p, i, 1'b1, ix, 2);
                push(12'h000, 3'b001, p, i, 1'b1, ix, 2);
            end
        endcase
    endtask

    task automatic cmp_rec(input rec_t e);
        check_eq("ctrl",    64'(obs_ctrl()), 64'(e.ctrl));
        check_eq("status",  64'({bus.busy, bus.done, bus.err}), 64'(e.stat));
        check_eq("pc",      64'(bus.pc), 64'(e.pc));
        check_eq("retired", 64'(bus.retired), 64'(e.ret));
        if (e.chk_idx)
            check_eq("regidx", 64'({bus.dst_reg, bus.src_a, bus.src_b}), 64'(e.idx));
    endtask

    // Walk the expected queue, leaving `keep` records unconsumed.
    task automatic run_queue(input int keep);
        rec_t e;
        while (q.size() > keep) begin
            e = q.pop_front();
            @(negedge clk);
            cmp_rec(e);
            bus.mul_done = (e.md == 2) ? 1'($urandom) : (e.md == 1);
            bus.start    = e.stat[2] ? 1'($urandom) : 1'b0;
            rec_no++;
        end
    endtask

    task automatic kick();
        @(negedge clk);
        check_eq("idle_busy", 64'(bus.busy), 64'd0);
        bus.start    = 1'b1;
        bus.mul_done = 1'($urandom);
    endtask

    initial begin
        rec_t e;
        logic [31:0] sw_word;
        bus.start    = 1'b0;
        bus.mul_done = 1'b0;
        rst_n        = 1'b0;

        for (int i = 0; i < 128; i++) begin
            imem[i] = 32'd0;
            cls[i]  = C_ILL;
            nmul[i] = 0;
        end
        for (int i = 0; i < N_INSTR; i++) begin
            cls[i]  = cls_t'($urandom_range(0, 3));
            imem[i] = mk_word(cls[i]);
            nmul[i] = $urandom_range(0, 3);
        end
        imem[0] = 32'b100011_01000_10000_0000001000000000; cls[0] = C_LW;
        imem[1] = 32'b000000_01110_01000_01001_00000_011000; cls[1] = C_MUL; nmul[1] = 3;
        cls[2] = C_SW;  imem[2] = mk_word(C_SW);
        cls[3] = C_ADD; imem[3] = mk_word(C_ADD);
        cls[4] = C_LW;  imem[4] = mk_word(C_LW);
        sw_word = imem[2];

        // Reset state
        repeat (2) @(negedge clk);
        check_eq("rst_ctrl",    64'(obs_ctrl()), 64'd0);
        check_eq("rst_status",  64'({bus.busy, bus.done, bus.err}), 64'd0);
        check_eq("rst_pc",      64'(bus.pc), 64'd0);
        check_eq("rst_retired", 64'(bus.retired), 64'd0);
        check_eq("rst_regidx",  64'({bus.dst_reg, bus.src_a, bus.src_b}), 64'd0);
        rst_n = 1'b1;

        // Full program to done
        kick();
        for (int i = 0; i < N_INSTR; i++) model_instr(i);
        push(12'h000, 3'b010, 4 * N_INSTR, N_INSTR, 1'b1,
             {imem[N_INSTR-1][25:21], imem[N_INSTR-1][20:16], imem[N_INSTR-1][15:11]}, 2);
        push(12'h000, 3'b010, 4 * N_INSTR, N_INSTR, 1'b0, 15'd0, 2);
        run_queue(0);

        // Restart from HALT; illegal opcode at pc 8
        imem[2] = {6'b000100, 26'($urandom)};
        cls[2]  = C_ILL;
        kick();
        for (int i = 0; i < 3; i++) model_instr(i);
        run_queue(0);

        // Restart, then async reset in the MEM_WB cycle of the lw at pc 16
        imem[2] = sw_word;
        cls[2]  = C_SW;
        kick();
        for (int i = 0; i < 5; i++) model_instr(i);
        run_queue(1);
        e = q.pop_front();
        @(negedge clk);
        cmp_rec(e);
        check_eq("wb_reg_write", 64'(bus.reg_write), 64'd1);
        bus.start = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check_eq("arst_reg_write", 64'(bus.reg_write), 64'd0);
        check_eq("arst_ctrl",      64'(obs_ctrl()), 64'd0);
        check_eq("arst_status",    64'({bus.busy, bus.done, bus.err}), 64'd0);
        check_eq("arst_pc",        64'(bus.pc), 64'd0);
        check_eq("arst_retired",   64'(bus.retired), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check_eq("post_rst_idle_ctrl",   64'(obs_ctrl()), 64'd0);
        check_eq("post_rst_idle_status", 64'({bus.busy, bus.done, bus.err}), 64'd0);
        check_eq("post_rst_pc",          64'(bus.pc), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
